// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM (IF/EX/MEM/WB) with bus-ready timeouts and a sticky trap.
// Define RV32M_MULDIV_EN to add the MD state that drives an external multiply/divide unit.
module multicycle_ctrl #(
  parameter int BUS_TIMEOUT = 16,
  parameter int TO_W        = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  input  logic       ifu_ready,
  input  logic       lsu_ready,
  input  logic       muldiv_done,
  output logic       InsFetch,
  output logic       RegWr,
  output logic       ALUAsrc,
  output logic       MemtoReg,
  output logic       MemWr,
  output logic       PCInc,
  output logic [2:0] ExtOP,
  output logic [1:0] ALUBsrc,
  output logic [3:0] ALUctr,
  output logic [2:0] Branch,
  output logic [2:0] MemOP,
  output logic       muldiv_start,
  output logic [2:0] muldiv_op,
  output logic       trap,
  output logic [1:0] trap_cause,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IF   = 3'b000,
    S_EX   = 3'b001,
    S_MEM  = 3'b010,
    S_WB   = 3'b011,
    S_MD   = 3'b100,
    S_TRAP = 3'b111
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(BUS_TIMEOUT - 1);

  state_t          state_q;
  logic [TO_W-1:0] cnt_q;
  logic            trap_q;
  logic [1:0]      cause_q;

  logic       legal, is_ld, is_st, is_md, dec_rw, dec_asrc;
  logic [2:0] dec_ext, dec_br;
  logic [1:0] dec_bsrc;
  logic [3:0] dec_alu;

  // alt selects SUB/SRA; SLTU needs its own code since {alt,func3} would collide
  function automatic logic [3:0] alu_sel(input logic [2:0] f3, input logic alt);
    return (f3 == 3'b011) ? 4'b1010 : {alt, f3};
  endfunction

  always_comb begin
    legal = 1'b0; is_ld = 1'b0; is_st = 1'b0; is_md = 1'b0;
    dec_rw = 1'b0; dec_asrc = 1'b0; dec_ext = '0; dec_bsrc = '0; dec_alu = '0; dec_br = '0;
    case (op)
      7'b0110111: begin legal = 1'b1; dec_rw = 1'b1; dec_ext = 3'b001; dec_bsrc = 2'b01; dec_alu = 4'b0011; end
      7'b0010111: begin legal = 1'b1; dec_rw = 1'b1; dec_asrc = 1'b1; dec_ext = 3'b001; dec_bsrc = 2'b01; end
      7'b1101111: begin
        legal = 1'b1; dec_rw = 1'b1; dec_asrc = 1'b1; dec_ext = 3'b100; dec_bsrc = 2'b10; dec_br = 3'b001;
      end
      7'b1100111: begin
        legal = (func3 == 3'b000); dec_rw = 1'b1; dec_asrc = 1'b1; dec_bsrc = 2'b10; dec_br = 3'b010;
      end
      7'b1100011: begin
        legal   = (func3[2:1] != 2'b01);
        dec_ext = 3'b011;
        dec_alu = func3[1] ? 4'b1010 : 4'b0010;
        dec_br  = {1'b1, func3[2], func3[0]};
      end
      7'b0000011: begin
        legal = (func3 != 3'b011) && (func3[2:1] != 2'b11); is_ld = 1'b1; dec_bsrc = 2'b01;
      end
      7'b0100011: begin
        legal = !func3[2] && (func3 != 3'b011); is_st = 1'b1; dec_ext = 3'b010; dec_bsrc = 2'b01;
      end
      7'b0010011: begin
        legal    = (func3 == 3'b001) ? (func7 == 7'b0000000) :
                   (func3 == 3'b101) ? (func7 == 7'b0000000 || func7 == 7'b0100000) : 1'b1;
        dec_rw   = 1'b1;
        dec_bsrc = 2'b01;
        dec_alu  = alu_sel(func3, (func3 == 3'b101) && func7[5]);
      end
      7'b0110011: begin
        dec_rw  = 1'b1;
        dec_alu = alu_sel(func3, func7[5]);
        if (func7 == 7'b0000000) legal = 1'b1;
        else if (func7 == 7'b0100000) legal = (func3 == 3'b000) || (func3 == 3'b101);
`ifdef RV32M_MULDIV_EN
        else if (func7 == 7'b0000001) begin legal = 1'b1; is_md = 1'b1; dec_rw = 1'b0; end
`endif
      end
      7'b0001111, 7'b1110011: legal = (func3 == 3'b000);
      default: legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IF;
      cnt_q   <= '0;
      trap_q  <= 1'b0;
      cause_q <= 2'b00;
    end else begin
      case (state_q)
        S_IF: begin
          if (ifu_ready) state_q <= S_EX;
          else if (cnt_q == TO_LAST) begin state_q <= S_TRAP; trap_q <= 1'b1; cause_q <= 2'b01; end
          else cnt_q <= cnt_q + 1'b1;
        end
        S_EX: begin
          if (!legal) begin state_q <= S_TRAP; trap_q <= 1'b1; cause_q <= 2'b10; end
          else if (is_ld || is_st) begin state_q <= S_MEM; cnt_q <= '0; end
          else if (is_md) state_q <= S_MD;
          else begin state_q <= S_IF; cnt_q <= '0; end
        end
        S_MEM: begin
          if (lsu_ready) begin
            if (is_st) begin state_q <= S_IF; cnt_q <= '0; end
            else state_q <= S_WB;
          end else if (cnt_q == TO_LAST) begin state_q <= S_TRAP; trap_q <= 1'b1; cause_q <= 2'b11; end
          else cnt_q <= cnt_q + 1'b1;
        end
        S_WB: begin state_q <= S_IF; cnt_q <= '0; end
`ifdef RV32M_MULDIV_EN
        S_MD: if (muldiv_done) begin state_q <= S_IF; cnt_q <= '0; end
`endif
        S_TRAP: state_q <= S_TRAP;
        default: begin state_q <= S_IF; cnt_q <= '0; end
      endcase
    end
  end

  // Strobes are gated by rst so an in-flight write is withdrawn without waiting for a clock.
  always_comb begin
    InsFetch = 1'b0; RegWr = 1'b0; ALUAsrc = 1'b0; MemtoReg = 1'b0; MemWr = 1'b0; PCInc = 1'b0;
    ExtOP = '0; ALUBsrc = '0; ALUctr = '0; Branch = '0; MemOP = 3'b111;
    muldiv_start = 1'b0; muldiv_op = '0;
    if (!rst) begin
      case (state_q)
        S_IF: InsFetch = 1'b1;
        S_EX: if (legal) begin
          ExtOP = dec_ext; ALUAsrc = dec_asrc; ALUBsrc = dec_bsrc; ALUctr = dec_alu; Branch = dec_br;
          if (!(is_ld || is_st || is_md)) begin RegWr = dec_rw; PCInc = 1'b1; end
          muldiv_start = is_md;
          if (is_md) muldiv_op = func3;
        end
        S_MEM: begin
          ExtOP = dec_ext; ALUAsrc = dec_asrc; ALUBsrc = dec_bsrc; ALUctr = dec_alu;
          MemOP = func3;
          MemWr = is_st;
          PCInc = is_st && lsu_ready;
        end
        S_WB: begin MemtoReg = 1'b1; RegWr = 1'b1; PCInc = 1'b1; end
`ifdef RV32M_MULDIV_EN
        S_MD: begin muldiv_op = func3; RegWr = muldiv_done; PCInc = muldiv_done; end
`endif
        default: ;
      endcase
    end
  end

`ifndef RV32M_MULDIV_EN
  logic unused_muldiv_done;
  assign unused_muldiv_done = muldiv_done;
`endif

  assign trap       = trap_q;
  assign trap_cause = cause_q;
  assign state      = state_q;

endmodule
